// File: rtl/fifo_rd_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fifo_rd_stream: read-side asy_fifo adapter, valid/ready out, word counter  |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module fifo_rd_stream #(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             rd_clk,
   input  logic             rd_rst_n,
   input  logic             fifo_empty,
   input  logic [WIDTH-1:0] rd_data,
   output logic             rd_en,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNT_W-1:0] word_cnt
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } occ_t;

   occ_t             r_occ;
   logic             r_inflight;
   logic             r_valid;
   logic             r_rd_ptr;
   logic             r_wr_ptr;
   logic [WIDTH-1:0] r_buf [2];
   logic [CNT_W-1:0] r_word_cnt;

   logic             w_pop;
   logic [2:0]       w_level;

   assign w_pop   = r_valid & out_ready;
   // Slots committed after this edge; a same-cycle pop frees one, hence the path from out_ready.
   assign w_level = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign rd_en   = rd_rst_n & ~fifo_empty & (w_level < 3'd2);

   always_ff @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         r_occ      <= EMPTY;
         r_inflight <= 1'b0;
         r_valid    <= 1'b0;
         r_rd_ptr   <= 1'b0;
         r_wr_ptr   <= 1'b0;
         r_buf[0]   <= '0;
         r_buf[1]   <= '0;
         r_word_cnt <= '0;
      end else begin
         r_inflight <= rd_en;
         if (r_inflight) begin
            r_buf[r_wr_ptr] <= rd_data;
            r_wr_ptr        <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr   <= ~r_rd_ptr;
            r_word_cnt <= r_word_cnt + 1'b1;
         end
         case ({r_inflight, w_pop})
            2'b10: begin
               r_occ   <= (r_occ == EMPTY) ? ONE : TWO;
               r_valid <= 1'b1;
            end
            2'b01: begin
               r_occ   <= (r_occ == TWO) ? ONE : EMPTY;
               r_valid <= (r_occ == TWO);
            end
            default: begin
            end
         endcase
      end
   end

   assign out_valid = r_valid;
   assign out_data  = r_buf[r_rd_ptr];
   assign word_cnt  = r_word_cnt;

   a_no_overflow : assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
      !((r_occ == TWO) && r_inflight && !w_pop));

endmodule
`default_nettype wire

// File: tb/tb_fifo_rd_stream.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fifo_rd_stream: FIFO model, table vectors and scoreboard for adapter    |
// | Rev 1.0                                                                    |
// +--------------------------------------------------------------------------+
module tb_fifo_rd_stream;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic             rd_clk;
   logic             rd_rst_n;
   logic             fifo_empty;
   logic [WIDTH-1:0] rd_data;
   logic             rd_en;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;
   logic [CNT_W-1:0] word_cnt;

   fifo_rd_stream #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .rd_clk     (rd_clk),
      .rd_rst_n   (rd_rst_n),
      .fifo_empty (fifo_empty),
      .rd_data    (rd_data),
      .rd_en      (rd_en),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_data   (out_data),
      .word_cnt   (word_cnt)
   );

   initial rd_clk = 1'b0;
   always #5 rd_clk = ~rd_clk;

   int n_vec  = 0;
   int n_fail = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // asy_fifo model: registered read data one cycle after rd_en
   logic [WIDTH-1:0] mem [0:255];
   int wr_idx = 0;
   int rd_idx = 0;
   int rd_cnt = 0;
   assign fifo_empty = (rd_idx == wr_idx);

   always @(posedge rd_clk or negedge rd_rst_n) begin
      if (!rd_rst_n) begin
         rd_idx <= wr_idx;
         rd_cnt <= 0;
      end else if (rd_en) begin
         rd_data <= mem[rd_idx[7:0]];
         rd_idx  <= rd_idx + 1;
         rd_cnt  <= rd_cnt + 1;
      end
   end

   logic [WIDTH-1:0] sb_q [$];
   int exp_cnt = 0;
   int pop_cnt = 0;

   always @(negedge rd_clk) begin
      if (!rd_rst_n) begin
         exp_cnt = 0;
         pop_cnt = 0;
      end else begin
         chk("word_cnt_track", 32'(word_cnt), 32'(exp_cnt % 16));
         chk("rd_en_while_empty", 32'(rd_en & fifo_empty), 32'd0);
         chk("outstanding_le_2", 32'(rd_cnt - pop_cnt <= 2), 32'd1);
         if (out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
               chk("sb_data", 32'(out_data), 32'(sb_q.pop_front()));
            end
            exp_cnt++;
            pop_cnt++;
         end
      end
   end

   task automatic push(input logic [WIDTH-1:0] w);
      mem[wr_idx[7:0]] = w;
      wr_idx = wr_idx + 1;
      sb_q.push_back(w);
   endtask

   task automatic step();
      @(posedge rd_clk);
      #2;
   endtask

   task automatic do_reset();
      rd_rst_n = 1'b0;
      sb_q.delete();
      step();
      step();
      rd_rst_n = 1'b1;
   endtask

   typedef struct {
      logic             rdy;
      logic             en;
      logic             vld;
      logic [WIDTH-1:0] dat;
   } vec_t;

   vec_t tbl [12];

   initial begin
      // Backpressure: A0..A4 preloaded, ready low six cycles then high
      tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'h00};
      tbl[1]  = '{1'b0, 1'b1, 1'b0, 8'h00};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'hA0};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'hA0};
      tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'hA0};
      tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'hA0};
      tbl[6]  = '{1'b1, 1'b1, 1'b1, 8'hA0};
      tbl[7]  = '{1'b1, 1'b1, 1'b1, 8'hA1};
      tbl[8]  = '{1'b1, 1'b1, 1'b1, 8'hA2};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'hA3};
      tbl[10] = '{1'b1, 1'b0, 1'b1, 8'hA4};
      tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h00};

      rd_rst_n  = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_rd_en",     32'(rd_en),     32'd0);
      chk("rst_word_cnt",  32'(word_cnt),  32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      step();
      step();
      rd_rst_n = 1'b1;

      for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
      for (int i = 0; i < 12; i++) begin
         out_ready = tbl[i].rdy;
         @(negedge rd_clk);
         chk($sformatf("bp_rd_en[%0d]", i), 32'(rd_en), 32'(tbl[i].en));
         chk($sformatf("bp_valid[%0d]", i), 32'(out_valid), 32'(tbl[i].vld));
         if (tbl[i].vld) chk($sformatf("bp_data[%0d]", i), 32'(out_data), 32'(tbl[i].dat));
         step();
      end

      // Streaming 0x11..0x18 with ready held high
      for (int i = 0; i < 8; i++) push(8'h11 + 8'(i));
      out_ready = 1'b1;
      for (int i = 0; i < 11; i++) begin
         @(negedge rd_clk);
         chk($sformatf("st_rd_en[%0d]", i), 32'(rd_en), 32'(i < 8));
         chk($sformatf("st_valid[%0d]", i), 32'(out_valid), 32'(i >= 2 && i <= 9));
         step();
      end
      chk("st_word_cnt", 32'(word_cnt), 32'd13);

      // Alternating ready
      for (int i = 0; i < 6; i++) push(8'hC0 + 8'(i));
      for (int i = 0; i < 24; i++) begin
         out_ready = (i % 2 == 0);
         step();
      end
      out_ready = 1'b1;
      @(negedge rd_clk);
      chk("alt_drained", 32'(sb_q.size()), 32'd0);
      chk("alt_word_cnt", 32'(word_cnt), 32'd3);
      step();

      // Reset with two words buffered and reads still pending in the FIFO
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) push(8'hB0 + 8'(i));
      for (int i = 0; i < 4; i++) step();
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      rd_rst_n = 1'b0;
      sb_q.delete();
      #1;
      chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_rd_en",     32'(rd_en),     32'd0);
      chk("mid_rst_word_cnt",  32'(word_cnt),  32'd0);
      step();
      step();
      rd_rst_n  = 1'b1;
      out_ready = 1'b1;
      push(8'h5A);
      @(negedge rd_clk);
      chk("lat_rd_en_c0", 32'(rd_en), 32'd1);
      chk("lat_valid_c0", 32'(out_valid), 32'd0);
      step();
      @(negedge rd_clk);
      chk("lat_valid_c1", 32'(out_valid), 32'd0);
      step();
      @(negedge rd_clk);
      chk("lat_valid_c2", 32'(out_valid), 32'd1);
      chk("lat_data_c2", 32'(out_data), 32'h5A);
      step();

      // Counter wrap: 18 pops on a 4-bit counter
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 18; i++) push(8'h30 + 8'(i));
      for (int i = 0; i < 24; i++) step();
      @(negedge rd_clk);
      chk("wrap_word_cnt", 32'(word_cnt), 32'd2);
      chk("wrap_drained", 32'(sb_q.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side adapter placed directly downstream of asy_fifo, in the rd_clk domain.
- Drives asy_fifo rd_en from fifo_empty and converts the FIFO's one-cycle registered read data into a valid/ready stream.
- A 2-entry output buffer sustains one word per cycle with no bubbles.
- Counts words delivered to the consumer.

Parameters:
- WIDTH, 8, data width; must match asy_fifo WIDTH.
- CNT_W, 16, width of the delivered-word counter.

Ports:
- rd_clk  input  1  read-domain clock; all logic on rising edge.
- rd_rst_n  input  1  asynchronous active-low reset.
- fifo_empty  input  1  asy_fifo empty flag.
- rd_data  input  WIDTH  asy_fifo read data; valid 1 cycle after an rd_en that was high while fifo_empty was low.
- rd_en  output  1  asy_fifo read enable.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer accepts the word.
- out_data  output  WIDTH  head word of the output buffer.
- word_cnt  output  CNT_W  number of words accepted by the consumer; wraps at 2^CNT_W.

Behaviour:
- Reset: one clock, rd_clk; asynchronous active-low reset, rd_rst_n. Asserting rd_rst_n low immediately clears:
  - occ to 0,
  - inflight to 0,
  - out_valid to 0,
  - out_data to 0,
  - word_cnt to 0,
  - all buffer entries to 0.
- rd_en is combinational and is forced to 0 while rd_rst_n is low.
- State:
  - occ in {0,1,2} (buffer occupancy); states EMPTY, ONE, TWO.
  - inflight: 1-bit register, set when the previous cycle issued a read.
- pop = out_valid & out_ready.
- rd_en = !fifo_empty & ((occ + inflight - pop) < 2).
  - rd_en is never high while fifo_empty is high.
  - rd_en has a combinational path from out_ready; this is intended.
- inflight <= rd_en (registered).
- Arrival: when inflight=1, rd_data is written into the buffer that cycle.
- Buffer is a 2-entry FIFO: head = buf[rd_ptr], 1-bit pointers.
- out_valid = (occ != 0), registered state.
- out_data = head entry.
- Occupancy transitions on each edge (arrive = inflight):
  - arrive & !pop: occ+1.
  - !arrive & pop: occ-1.
  - arrive & pop (simultaneous): occ unchanged; new word written at wr_ptr, head advances.
  - neither: hold.
- Overflow of the buffer is impossible by the rd_en rule. An implementation assertion flags occ=2 & arrive & !pop.
- Latency: word present in FIFO with buffer empty -> rd_en same cycle -> out_valid high 2 edges later (rd_en edge, then data capture edge).
- Throughput: with out_ready held high and FIFO non-empty, exactly one word per cycle after the initial 2-cycle fill.
- Backpressure: out_ready low with out_valid high:
  - out_data and out_valid hold stable;
  - at most 2 words buffered;
  - rd_en deasserts once occ+inflight reaches 2.
- word_cnt increments by 1 on every pop and wraps from 2^CNT_W-1 to 0.
- Ordering: words leave in exactly the order read from the FIFO; no loss, no duplication.
- Reset mid-operation: any in-flight read is discarded. asy_fifo is reset by the same rd_rst_n in the system, so no word is lost relative to the FIFO.
- fifo_empty deasserting while occ=2: no read until a pop frees a slot.

Test Plan:
- Reset: rd_rst_n low at any time (incl. with occ=2) -> out_valid=0, rd_en=0, word_cnt=0 asynchronously; after release, first word appears at expected 2-edge latency.
- Streaming: FIFO model holds 8 words 0x11..0x18, out_ready=1 -> rd_en high 8 consecutive cycles; out_data 0x11..0x18 on 8 consecutive cycles; word_cnt=8; rd_en low after fifo_empty rises.
- Backpressure: 5 words 0xA0..0xA4, out_ready=0 for 6 cycles, then 1:
  - rd_en fires exactly twice, then stays low;
  - out_data holds 0xA0 stable;
  - after release, 0xA0..0xA4 are delivered in order.
- Alternating out_ready (1,0,1,0...) with 6 words:
  - ordering preserved;
  - occ never exceeds 2;
  - rd_en never high while fifo_empty=1;
  - word_cnt=6.
- Simultaneous arrive & pop at occ=1: next word delivered the following cycle with occ still 1.
- Wrap: CNT_W=4, 18 pops -> word_cnt reads 2.
